mdu_iter: RTL

Iterative multiply/divide unit implementing the eight RV32M operations over a parametrised datapath width. It sits beside the single-cycle integer ALU in the execute stage. Decode steers M-extension instructions here through a valid/ready handshake, and execute stalls until the result is consumed. Computation is radix-2, one bit per cycle, with single-cycle early-out for RISC-V-defined divide corner cases and a kill input for pipeline flushes.

---
 rtl/mdu_iter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/mdu_iter.sv
// mdu_iter: iterative radix-2 multiply/divide unit for the eight RV32M operations.
// One product/quotient bit per cycle. Divide-by-zero and signed overflow finish
// directly at accept. kill abandons any operation in flight.
module mdu_iter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned CNTW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int unsigned PW = 2 * XLEN;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [XLEN-1:0] ZERO_X = '0;
  localparam logic [XLEN-1:0] ONES_X = '1;
  localparam logic [XLEN-1:0] MIN_X  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [PW-1:0]   ZERO_P = '0;
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;     // product / quotient needs negation
  logic              rneg_q, rneg_d;   // remainder needs negation
  logic [XLEN-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [PW-1:0]     acc_q, acc_d;     // {hi, lo} working register
  logic [XLEN-1:0]   result_q, result_d;

  // Accept-time decode: signedness, magnitudes and early-out conditions
  logic            rs1_signed_c, rs2_signed_c;
  logic            s1_c, s2_c;
  logic [XLEN-1:0] mag1_c, mag2_c;
  logic            div_zero_c, div_ovf_c;
  logic [XLEN-1:0] early_res_c;

  always_comb begin
    rs1_signed_c = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    rs2_signed_c = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    s1_c         = rs1_signed_c & rs1[XLEN-1];
    s2_c         = rs2_signed_c & rs2[XLEN-1];
    mag1_c       = s1_c ? (ZERO_X - rs1) : rs1;
    mag2_c       = s2_c ? (ZERO_X - rs2) : rs2;
    div_zero_c   = op[2] && (rs2 == ZERO_X);
    div_ovf_c    = ((op == OP_DIV) || (op == OP_REM)) && (rs1 == MIN_X) && (rs2 == ONES_X);
    early_res_c  = ZERO_X;
    if (div_zero_c) begin
      early_res_c = op[1] ? rs1 : ONES_X;
    end else if (div_ovf_c) begin
      early_res_c = op[1] ? ZERO_X : rs1;
    end
  end

  // One iteration step: shift-add for multiply, restoring subtract for divide
  logic [XLEN:0]   mul_sum_c;
  logic [PW-1:0]   mul_step_c;
  logic [XLEN:0]   div_cand_c;
  logic [XLEN:0]   div_diff_c;
  logic            div_ge_c;
  logic [XLEN-1:0] div_rem_c;
  logic [PW-1:0]   div_step_c;
  logic [PW-1:0]   step_c;

  always_comb begin
    mul_sum_c  = {1'b0, acc_q[PW-1:XLEN]} + {1'b0, opnd_q};
    mul_step_c = acc_q[0] ? {mul_sum_c, acc_q[XLEN-1:1]} : {1'b0, acc_q[PW-1:1]};
    div_cand_c = acc_q[PW-1:XLEN-1];
    div_ge_c   = div_cand_c >= {1'b0, opnd_q};
    div_diff_c = div_cand_c - {1'b0, opnd_q};
    div_rem_c  = div_ge_c ? XLEN'(div_diff_c) : XLEN'(div_cand_c);
    div_step_c = {div_rem_c, acc_q[XLEN-2:0], div_ge_c};
    step_c     = op_q[2] ? div_step_c : mul_step_c;
  end

  // Sign fix-up and result selection applied to the final iteration value
  logic [PW-1:0]   prod_c;
  logic [XLEN-1:0] quo_c, remd_c;
  logic [XLEN-1:0] final_res_c;

  always_comb begin
    prod_c      = neg_q ? (ZERO_P - step_c) : step_c;
    quo_c       = neg_q ? (ZERO_X - step_c[XLEN-1:0]) : step_c[XLEN-1:0];
    remd_c      = rneg_q ? (ZERO_X - step_c[PW-1:XLEN]) : step_c[PW-1:XLEN];
    final_res_c = ZERO_X;
    case (op_q)
      OP_MUL:                        final_res_c = prod_c[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  final_res_c = prod_c[PW-1:XLEN];
      OP_DIV, OP_DIVU:               final_res_c = quo_c;
      OP_REM, OP_REMU:               final_res_c = remd_c;
      default:                       final_res_c = ZERO_X;
    endcase
  end

  // Next-state and datapath update; kill overrides everything
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;

    if (kill) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_d   = op;
            neg_d  = s1_c ^ s2_c;
            rneg_d = s1_c;
            cnt_d  = CNT_LOAD;
            if (op[2]) begin
              opnd_d = mag2_c;
              acc_d  = {ZERO_X, mag1_c};
            end else begin
              opnd_d = mag1_c;
              acc_d  = {ZERO_X, mag2_c};
            end
            if (div_zero_c || div_ovf_c) begin
              result_d = early_res_c;
              state_d  = S_DONE;
            end else begin
              state_d  = S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_d = step_c;
          if (cnt_q == '0) begin
            result_d = final_res_c;
            state_d  = S_DONE;
          end else begin
            cnt_d = cnt_q - CNTW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;

endmodule
